// File: rtl/kc_dl_pkg.sv
// Shared types and defaults for the KC85 HPS download router.
package kc_dl_pkg;

  localparam int IDX_BASE_DEF = 1;
  localparam int TAP_SKIP_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_REQ,
    ST_FLUSH,
    ST_DONE
  } kc_dl_state_t;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/kc_dl_router_if.sv
// Memory write port bundle shared by all router channels; req/ack are one bit per channel.
interface kc_dl_router_if #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  import kc_dl_pkg::*;

  logic [NCH-1:0]           mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data;
  logic [lanes(DATA_W)-1:0] mem_be;
  logic [NCH-1:0]           mem_ack;

  modport master (output mem_req, mem_addr, mem_data, mem_be, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_data, mem_be, output mem_ack);

endinterface

// File: rtl/kc_dl_packer.sv
// Packs payload bytes into DATA_W words: lane placement, byte-enable accumulation, word address, overflow.
module kc_dl_packer
  import kc_dl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     clr_be,
  input  logic                     wr,
  input  logic [7:0]               din,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic [lanes(DATA_W)-1:0] be,
  output logic [ADDR_W+1:0]        len,
  output logic                     stored,
  output logic                     last,
  output logic                     drop
);

  localparam int LN = lanes(DATA_W);
  localparam int PW = ADDR_W + $clog2(LN) + 1;

  // pos saturates once its top bit sets: the next word address would not fit.
  logic [PW-1:0] pos;
  logic [PW-1:0] lane;
  logic          full;

  assign full   = pos[PW-1];
  assign lane   = pos % PW'(LN);
  assign stored = wr && !full;
  assign drop   = wr && full;
  assign last   = stored && (lane == PW'(LN - 1));
  assign len    = (ADDR_W+2)'(pos);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos  <= '0;
      addr <= '0;
      data <= '0;
      be   <= '0;
    end else begin
      if (clr_be) begin
        be   <= '0;
        data <= '0;
      end
      if (stored) begin
        data <= data | (DATA_W'(din) << {lane, 3'b000});
        be   <= be | (LN'(1) << lane);
        addr <= ADDR_W'(pos / PW'(LN));
        pos  <= pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kc_dl_router.sv
// kc_dl_router: demultiplexes hps_io ioctl downloads by index onto NCH packed memory write ports.
// Define KC_DL_CHECKSUM_EN to add dl_sum, the modulo-256 sum of stored bytes.
module kc_dl_router
  import kc_dl_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int IDX_BASE = IDX_BASE_DEF,
  parameter int TAP_SKIP = TAP_SKIP_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  kc_dl_router_if.master    mem,
  output logic [NCH-1:0]    dl_done,
  output logic [ADDR_W+1:0] dl_len,
`ifdef KC_DL_CHECKSUM_EN
  output logic [7:0]        dl_sum,
`endif
  output logic              dl_err
);

  localparam int LANES = lanes(DATA_W);
  localparam int SKW   = $clog2(TAP_SKIP + 2);

  kc_dl_state_t       state;
  logic [7:0]         ch;
  logic               valid;
  logic               end_pend;
  logic [SKW-1:0]     skip_cnt;
  logic [NCH-1:0]     req_q;
  logic [NCH-1:0]     ch_oh;
  logic [7:0]         idx_rel;
  logic               start, byte_in, skipping, ack_hit;
  logic               pk_wr, pk_stored, pk_last, pk_drop;
  logic [ADDR_W-1:0]  pk_addr;
  logic [DATA_W-1:0]  pk_data;
  logic [LANES-1:0]   pk_be;
  logic [ADDR_W+1:0]  pk_len;
  logic               unused_addr;

  // The internal byte counter is authoritative; the HPS byte address is ignored.
  assign unused_addr = ^ioctl_addr;

  assign idx_rel  = ioctl_index - 8'(IDX_BASE);
  assign ch_oh    = valid ? (NCH'(1) << ch) : '0;
  assign start    = (state == ST_IDLE) && ioctl_download;
  assign byte_in  = (state == ST_ACTIVE) && ioctl_wr;
  assign skipping = (ch == 8'd0) && (skip_cnt < SKW'(TAP_SKIP));
  assign pk_wr    = byte_in && valid && !skipping;
  assign ack_hit  = ((state == ST_REQ) || (state == ST_FLUSH)) && |(mem.mem_ack & req_q);

  kc_dl_packer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk    (clk_sys),
    .rst    (reset),
    .clr    (start),
    .clr_be (ack_hit),
    .wr     (pk_wr),
    .din    (ioctl_data),
    .addr   (pk_addr),
    .data   (pk_data),
    .be     (pk_be),
    .len    (pk_len),
    .stored (pk_stored),
    .last   (pk_last),
    .drop   (pk_drop)
  );

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pk_addr;
  assign mem.mem_data = pk_data;
  assign mem.mem_be   = pk_be;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      ch         <= '0;
      valid      <= 1'b0;
      end_pend   <= 1'b0;
      skip_cnt   <= '0;
      req_q      <= '0;
      ioctl_wait <= 1'b0;
      dl_done    <= '0;
      dl_len     <= '0;
      dl_err     <= 1'b0;
    end else begin
      dl_done <= '0;
      if (pk_drop) dl_err <= 1'b1;
      if (byte_in && skipping) skip_cnt <= skip_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (ioctl_download) begin
            ch       <= idx_rel;
            valid    <= idx_rel < 8'(NCH);
            skip_cnt <= '0;
            end_pend <= 1'b0;
            dl_err   <= 1'b0;
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A byte strobed in the same cycle the download falls is still stored.
          if (pk_last) begin
            req_q      <= ch_oh;
            ioctl_wait <= 1'b1;
            end_pend   <= !ioctl_download;
            state      <= ST_REQ;
          end else if (!ioctl_download) begin
            if (pk_stored || (pk_be != '0)) begin
              req_q      <= ch_oh;
              ioctl_wait <= 1'b1;
              state      <= ST_FLUSH;
            end else begin
              dl_done <= ch_oh;
              dl_len  <= pk_len;
              state   <= ST_DONE;
            end
          end
        end
        ST_REQ, ST_FLUSH: begin
          if (!ioctl_download) end_pend <= 1'b1;
          if (ack_hit) begin
            req_q      <= '0;
            ioctl_wait <= 1'b0;
            if ((state == ST_FLUSH) || end_pend || !ioctl_download) begin
              dl_done <= ch_oh;
              dl_len  <= pk_len;
              state   <= ST_DONE;
            end else begin
              state <= ST_ACTIVE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef KC_DL_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset || start) dl_sum <= '0;
    else if (pk_stored) dl_sum <= dl_sum + ioctl_data;
  end
`endif

endmodule

// File: tb/tb_kc_dl_router.sv
// Directed bench for kc_dl_router: three configurations share one ioctl bus; sel picks the DUT under test.
module tb_kc_dl_router;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dl = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] idx = 8'd0;
  logic [7:0] dat = 8'd0;

  always #5 clk = ~clk;

  kc_dl_router_if #(.NCH(4), .ADDR_W(16), .DATA_W(8))  if0 ();
  kc_dl_router_if #(.NCH(4), .ADDR_W(16), .DATA_W(16)) if1 ();
  kc_dl_router_if #(.NCH(4), .ADDR_W(2),  .DATA_W(8))  if2 ();

  logic        wait_a [3];
  logic [3:0]  done_a [3];
  logic [17:0] len_a  [3];
  logic        err_a  [3];
  logic [3:0]  req_a  [3];
  logic [15:0] addr_a [3];
  logic [15:0] data_a [3];
  logic [1:0]  be_a   [3];
  logic [3:0]  ack_a  [3];
  logic [3:0]  len2;
`ifdef KC_DL_CHECKSUM_EN
  logic [7:0]  sum0, sum1, sum2;
`endif

  kc_dl_router #(.NCH(4), .ADDR_W(16), .DATA_W(8), .IDX_BASE(1), .TAP_SKIP(16)) u0 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(25'd0), .ioctl_data(dat), .ioctl_wait(wait_a[0]), .mem(if0),
    .dl_done(done_a[0]), .dl_len(len_a[0]),
`ifdef KC_DL_CHECKSUM_EN
    .dl_sum(sum0),
`endif
    .dl_err(err_a[0]));

  kc_dl_router #(.NCH(4), .ADDR_W(16), .DATA_W(16), .IDX_BASE(1), .TAP_SKIP(0)) u1 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(25'd0), .ioctl_data(dat), .ioctl_wait(wait_a[1]), .mem(if1),
    .dl_done(done_a[1]), .dl_len(len_a[1]),
`ifdef KC_DL_CHECKSUM_EN
    .dl_sum(sum1),
`endif
    .dl_err(err_a[1]));

  kc_dl_router #(.NCH(4), .ADDR_W(2), .DATA_W(8), .IDX_BASE(1), .TAP_SKIP(0)) u2 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(25'd0), .ioctl_data(dat), .ioctl_wait(wait_a[2]), .mem(if2),
    .dl_done(done_a[2]), .dl_len(len2),
`ifdef KC_DL_CHECKSUM_EN
    .dl_sum(sum2),
`endif
    .dl_err(err_a[2]));

  assign len_a[2]    = 18'(len2);
  assign req_a[0]    = if0.mem_req;
  assign req_a[1]    = if1.mem_req;
  assign req_a[2]    = if2.mem_req;
  assign addr_a[0]   = if0.mem_addr;
  assign addr_a[1]   = if1.mem_addr;
  assign addr_a[2]   = 16'(if2.mem_addr);
  assign data_a[0]   = 16'(if0.mem_data);
  assign data_a[1]   = if1.mem_data;
  assign data_a[2]   = 16'(if2.mem_data);
  assign be_a[0]     = 2'(if0.mem_be);
  assign be_a[1]     = if1.mem_be;
  assign be_a[2]     = 2'(if2.mem_be);
  assign if0.mem_ack = ack_a[0];
  assign if1.mem_ack = ack_a[1];
  assign if2.mem_ack = ack_a[2];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [3:0]  ch;
  } wr_t;

  wr_t        log_q[$];
  logic [7:0] tx[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         sel = 0;
  int         dly [3] = '{0, 0, 0};
  bit         wrong_ack = 1'b0;
  int         cnt [3] = '{0, 0, 0};
  logic [15:0] h_addr [3];
  logic [15:0] h_data [3];
  logic [1:0]  h_be   [3];
  int         stab_err = 0;
  int         run = 0;
  int         max_run = 0;
  int         done_cnt = 0;
  logic [3:0] done_val = 4'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side responder: acks after dly cycles, optionally spraying acks on the other channels meanwhile.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (req_a[d] != 4'h0) begin
        if (cnt[d] == 0) begin
          h_addr[d] = addr_a[d];
          h_data[d] = data_a[d];
          h_be[d]   = be_a[d];
        end else if (d == sel && {addr_a[d], data_a[d], be_a[d]} != {h_addr[d], h_data[d], h_be[d]}) begin
          stab_err++;
        end
        if (cnt[d] >= dly[d]) begin
          ack_a[d] = req_a[d];
          if (d == sel) log_q.push_back('{addr_a[d], data_a[d], be_a[d], req_a[d]});
        end else begin
          ack_a[d] = wrong_ack ? ~req_a[d] : 4'h0;
        end
        cnt[d]++;
      end else begin
        cnt[d]   = 0;
        ack_a[d] = 4'h0;
      end
    end
    if (wait_a[sel]) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (done_a[sel] != 4'h0) begin
      done_cnt++;
      done_val = done_a[sel];
    end
  end

  task automatic clear_obs();
    log_q.delete();
    done_cnt = 0;
    done_val = 4'h0;
    max_run  = 0;
    stab_err = 0;
  endtask

  task automatic send(input logic [7:0] index, input bit fall_last);
    int g;
    @(negedge clk);
    idx = index;
    dl  = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < tx.size(); i++) begin
      g = 0;
      while (wait_a[sel] && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) chk("wait_release", 32'(wait_a[sel]), 0);
      wr  = 1'b1;
      dat = tx[i];
      if (fall_last && i == tx.size() - 1) dl = 1'b0;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
    end
    dl = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [3:0] ch);
    if (i < log_q.size()) begin
      chk({tag, "_addr"}, 32'(log_q[i].a), 32'(a));
      chk({tag, "_data"}, 32'(log_q[i].d), 32'(d));
      chk({tag, "_be"},   32'(log_q[i].be), 32'(be));
      chk({tag, "_ch"},   32'(log_q[i].ch), 32'(ch));
    end else begin
      chk({tag, "_present"}, log_q.size(), i + 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wait", 32'(wait_a[0]), 0);
    chk("rst_req",  32'(req_a[0]), 0);
    chk("rst_addr", 32'(addr_a[0]), 0);
    chk("rst_data", 32'(data_a[1]), 0);
    chk("rst_be",   32'(be_a[1]), 0);
    chk("rst_done", 32'(done_a[0]), 0);
    chk("rst_len",  32'(len_a[0]), 0);
    chk("rst_err",  32'(err_a[0]), 0);

    // ch1, byte-wide, immediate ack
    sel = 0;
    clear_obs();
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(8'd2, 1'b0);
    chk("t1_nwr", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t1_w%0d", i), i, 16'(i), 16'(tx[i]), 2'b01, 4'b0010);
    chk("t1_done_n",  done_cnt, 1);
    chk("t1_done_ch", 32'(done_val), 32'h2);
    chk("t1_len",     32'(len_a[0]), 4);
    chk("t1_err",     32'(err_a[0]), 0);

    // ch0 drops a 16-byte header; last byte strobed as the download falls
    clear_obs();
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'(i));
    send(8'd1, 1'b1);
    chk("t2_nwr", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t2_w%0d", i), i, 16'(i), 16'(16 + i), 2'b01, 4'b0001);
    chk("t2_done_ch", 32'(done_val), 32'h1);
    chk("t2_len",     32'(len_a[0]), 4);

    // 16-bit packing with a partial flush word
    sel = 1;
    clear_obs();
    tx = '{8'hAA, 8'hBB, 8'hCC};
    send(8'd2, 1'b0);
    chk("t3_nwr", log_q.size(), 2);
    chk_wr("t3_w0", 0, 16'd0, 16'hBBAA, 2'b11, 4'b0010);
    chk_wr("t3_w1", 1, 16'd1, 16'h00CC, 2'b01, 4'b0010);
    chk("t3_done_ch", 32'(done_val), 32'h2);
    chk("t3_len",     32'(len_a[1]), 3);

    // slow ack with stray acks on other channels
    sel = 0;
    dly[0] = 5;
    wrong_ack = 1'b1;
    clear_obs();
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send(8'd2, 1'b0);
    chk("t4_nwr", log_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_wr($sformatf("t4_w%0d", i), i, 16'(i), 16'(i + 1), 2'b01, 4'b0010);
    chk("t4_wait_run", max_run, 6);
    chk("t4_stable",   stab_err, 0);
    chk("t4_len",      32'(len_a[0]), 5);
    chk("t4_done_n",   done_cnt, 1);
    dly[0] = 0;
    wrong_ack = 1'b0;

    // 4-word target overflows after 4 bytes
    sel = 2;
    clear_obs();
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(8'd2, 1'b0);
    chk("t5_nwr", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t5_w%0d", i), i, 16'(i), 16'(i + 1), 2'b01, 4'b0010);
    chk("t5_err",     32'(err_a[2]), 1);
    chk("t5_len",     32'(len_a[2]), 4);
    chk("t5_done_ch", 32'(done_val), 32'h2);

    // unmapped index
    sel = 0;
    clear_obs();
    tx = '{8'h10, 8'h20, 8'h30, 8'h40};
    send(8'd9, 1'b0);
    chk("t6_nwr",    log_q.size(), 0);
    chk("t6_done_n", done_cnt, 0);
    chk("t6_err",    32'(err_a[0]), 0);

    // reset while a request is outstanding
    dly[0] = 50;
    clear_obs();
    @(negedge clk);
    idx = 8'd2;
    dl  = 1'b1;
    repeat (2) @(negedge clk);
    wr  = 1'b1;
    dat = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    chk("t7_req_hi",  32'(req_a[0]), 32'h2);
    chk("t7_wait_hi", 32'(wait_a[0]), 1);
    reset = 1'b1;
    dl    = 1'b0;
    @(negedge clk);
    chk("t7_req_lo",  32'(req_a[0]), 0);
    chk("t7_wait_lo", 32'(wait_a[0]), 0);
    chk("t7_be_lo",   32'(be_a[1]), 0);
    reset  = 1'b0;
    dly[0] = 0;
    clear_obs();
    tx = '{8'h77, 8'h88};
    send(8'd2, 1'b0);
    chk("t7_nwr", log_q.size(), 2);
    chk_wr("t7_w0", 0, 16'd0, 16'h0077, 2'b01, 4'b0010);
    chk_wr("t7_w1", 1, 16'd1, 16'h0088, 2'b01, 4'b0010);
    chk("t7_len", 32'(len_a[0]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
